mem_rr_arbiter: RTL and testbench

- Parametrised, work-conserving round-robin arbiter between N per-port controllers and the shared single-write/single-read packet buffer.
- Write and read channels are arbitrated independently, using a valid/grant handshake.
- Issued memory commands are registered.
- Read returns with variable latency are routed back to the issuing port through an in-order tag FIFO of port indices.
- Replaces the fixed time-slot rotation.

---
 rtl/mem_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Round-robin write/read arbiter in front of the shared packet buffer.
// Define ARB_LOCK_EN to let a locked write requester keep its grant.
module mem_rr_arbiter #(
  parameter int N          = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 512,
  parameter int MAX_OUTST  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N-1:0]                   wr_req_i,
  input  logic [N*ADDR_W-1:0]            wr_addr_i,
  input  logic [N*BLOCK_BITS-1:0]        wr_data_i,
  input  logic [N-1:0]                   wr_lock_i,
  output logic [N-1:0]                   wr_gnt_o,
  output logic                           mem_we_o,
  output logic [ADDR_W-1:0]              mem_waddr_o,
  output logic [BLOCK_BITS-1:0]          mem_wdata_o,
  input  logic [N-1:0]                   rd_req_i,
  input  logic [N*ADDR_W-1:0]            rd_addr_i,
  output logic [N-1:0]                   rd_gnt_o,
  output logic                           mem_re_o,
  output logic [ADDR_W-1:0]              mem_raddr_o,
  input  logic                           mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0]          mem_rdata_i,
  output logic [N-1:0]                   rd_valid_o,
  output logic [BLOCK_BITS-1:0]          rd_data_o,
  output logic [$clog2(MAX_OUTST+1)-1:0] rd_outst_o,
  output logic                           err_o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  function automatic logic [N-1:0] rr_pick(
    input logic [N-1:0]  req,
    input logic [PW-1:0] ptr
  );
    logic [N-1:0] g;
    logic         found;
    int           idx;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] enc(input logic [N-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) r = PW'(i);
    end
    return r;
  endfunction

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_waddr_q, mem_waddr_d;
  logic [BLOCK_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]     mem_raddr_q, mem_raddr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         head_q, head_d;
  logic [FW-1:0]         tail_q, tail_d;
  logic                  err_q, err_d;
  logic [PW-1:0]         tag_q [MAX_OUTST];
  logic [PW-1:0]         tag_d [MAX_OUTST];

  logic [N-1:0]  wr_gnt, rd_gnt;
  logic [PW-1:0] wr_sel, rd_sel;
  logic          wr_hold, push, pop;

`ifdef ARB_LOCK_EN
  // mem_we_q marks that wr_ptr_q was granted in the previous cycle
  assign wr_hold = mem_we_q && wr_req_i[wr_ptr_q] && wr_lock_i[wr_ptr_q];
`else
  logic unused_lock;
  assign unused_lock = ^wr_lock_i;
  assign wr_hold     = 1'b0;
`endif

  always_comb begin
    wr_gnt = rr_pick(wr_req_i, wr_ptr_q);
    if (wr_hold) wr_gnt = {{(N-1){1'b0}}, 1'b1} << wr_ptr_q;
    wr_sel = enc(wr_gnt);
    rd_gnt = '0;
    if (cnt_q != CW'(MAX_OUTST)) rd_gnt = rr_pick(rd_req_i, rd_ptr_q);
    rd_sel = enc(rd_gnt);
    push   = |rd_gnt;
    pop    = mem_rvalid_i && (cnt_q != '0);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_we_d    = |wr_gnt;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = push;
    mem_raddr_d = mem_raddr_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    err_d       = err_q | (mem_rvalid_i && (cnt_q == '0));
    tag_d       = tag_q;
    if (|wr_gnt) begin
      wr_ptr_d    = wr_sel;
      mem_waddr_d = wr_addr_i[wr_sel*ADDR_W +: ADDR_W];
      mem_wdata_d = wr_data_i[wr_sel*BLOCK_BITS +: BLOCK_BITS];
    end
    if (push) begin
      rd_ptr_d      = rd_sel;
      mem_raddr_d   = rd_addr_i[rd_sel*ADDR_W +: ADDR_W];
      tag_d[tail_q] = rd_sel;
      tail_d = (tail_q == FW'(MAX_OUTST - 1)) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == FW'(MAX_OUTST - 1)) ? '0 : head_q + 1'b1;
    end
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= PW'(N - 1);
      rd_ptr_q    <= PW'(N - 1);
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      err_q       <= 1'b0;
      tag_q       <= '{default: '0};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
    end
  end

  assign wr_gnt_o    = wr_gnt;
  assign rd_gnt_o    = rd_gnt;
  assign mem_we_o    = mem_we_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_re_o    = mem_re_q;
  assign mem_raddr_o = mem_raddr_q;
  assign rd_outst_o  = cnt_q;
  assign err_o       = err_q;
  assign rd_data_o   = mem_rdata_i;
  assign rd_valid_o  = pop ? ({{(N-1){1'b0}}, 1'b1} << tag_q[head_q]) : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: grant order, latency,
// read tag routing, outstanding limit, error flag and lock.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int BB = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    wr_req_i;
  logic [N*AW-1:0] wr_addr_i;
  logic [N*BB-1:0] wr_data_i;
  logic [N-1:0]    wr_lock_i;
  logic [N-1:0]    wr_gnt_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_waddr_o;
  logic [BB-1:0]   mem_wdata_o;
  logic [N-1:0]    rd_req_i;
  logic [N*AW-1:0] rd_addr_i;
  logic [N-1:0]    rd_gnt_o;
  logic            mem_re_o;
  logic [AW-1:0]   mem_raddr_o;
  logic            mem_rvalid_i;
  logic [BB-1:0]   mem_rdata_i;
  logic [N-1:0]    rd_valid_o;
  logic [BB-1:0]   rd_data_o;
  logic [CW-1:0]   rd_outst_o;
  logic            err_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(
    .N(N), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_lock_i(wr_lock_i),
    .wr_gnt_o(wr_gnt_o), .mem_we_o(mem_we_o),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
    .rd_gnt_o(rd_gnt_o), .mem_re_o(mem_re_o),
    .mem_raddr_o(mem_raddr_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .rd_outst_o(rd_outst_o),
    .err_o(err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    wr_req_i     = '0;
    wr_lock_i    = '0;
    rd_req_i     = '0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({mem_we_o, mem_re_o, err_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000",
               {mem_we_o, mem_re_o, err_o});
    end
    vectors++;
    if ({mem_waddr_o, mem_raddr_o, mem_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h/%h/%h expected 0",
               mem_waddr_o, mem_raddr_o, mem_wdata_o);
    end
    vectors++;
    if (rd_outst_o !== '0 || wr_gnt_o !== '0 || rd_gnt_o !== '0) begin
      miscompares++;
      $display("FAIL reset_cnt_gnt: got %0d/%b/%b expected 0",
               rd_outst_o, wr_gnt_o, rd_gnt_o);
    end
  endtask

  task automatic test_rr_all();
    int p [5];
    p = '{0, 1, 2, 3, 0};
    wr_req_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (wr_gnt_o !== 4'(1 << p[i])) begin
        miscompares++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b",
                 i, wr_gnt_o, 4'(1 << p[i]));
      end
      tick();
      vectors++;
      if (mem_we_o !== 1'b1 || mem_waddr_o !== AW'(256 + p[i]) ||
          mem_wdata_o !== BB'(32'hA000_0000 + p[i])) begin
        miscompares++;
        $display("FAIL rr_mem[%0d]: got %b/%h/%h expected 1/%h/%h",
                 i, mem_we_o, mem_waddr_o, mem_wdata_o,
                 AW'(256 + p[i]), BB'(32'hA000_0000 + p[i]));
      end
    end
    wr_req_i = '0;
    #1;
    vectors++;
    if (wr_gnt_o !== '0) begin
      miscompares++;
      $display("FAIL idle_gnt: got %b expected 0000", wr_gnt_o);
    end
    tick();
    vectors++;
    if (mem_we_o !== 1'b0 || mem_waddr_o !== AW'(256)) begin
      miscompares++;
      $display("FAIL idle_hold: got %b/%h expected 0/100",
               mem_we_o, mem_waddr_o);
    end
  endtask

  task automatic test_work_conserving();
    wr_req_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (wr_gnt_o !== 4'b0100) begin
        miscompares++;
        $display("FAIL solo_gnt[%0d]: got %b expected 0100",
                 i, wr_gnt_o);
      end
      tick();
      vectors++;
      if (mem_we_o !== 1'b1 || mem_waddr_o !== AW'(258)) begin
        miscompares++;
        $display("FAIL solo_mem[%0d]: got %b/%h expected 1/102",
                 i, mem_we_o, mem_waddr_o);
      end
    end
    wr_req_i = 4'b1001;
    #1;
    vectors++;
    if (wr_gnt_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL after_solo: got %b expected 1000", wr_gnt_o);
    end
    tick();
    wr_req_i = '0;
  endtask

  task automatic test_read_order();
    int p [3];
    p = '{1, 3, 0};
    for (int i = 0; i < 3; i++) begin
      rd_req_i = 4'(1 << p[i]);
      #1;
      vectors++;
      if (rd_gnt_o !== 4'(1 << p[i])) begin
        miscompares++;
        $display("FAIL rd_gnt[%0d]: got %b expected %b",
                 i, rd_gnt_o, 4'(1 << p[i]));
      end
      tick();
      vectors++;
      if (mem_re_o !== 1'b1 || mem_raddr_o !== AW'(512 + p[i])) begin
        miscompares++;
        $display("FAIL rd_issue[%0d]: got %b/%h expected 1/%h",
                 i, mem_re_o, mem_raddr_o, AW'(512 + p[i]));
      end
    end
    rd_req_i = '0;
    vectors++;
    if (rd_outst_o !== CW'(3)) begin
      miscompares++;
      $display("FAIL rd_outst3: got %0d expected 3", rd_outst_o);
    end
    for (int i = 0; i < 3; i++) begin
      repeat (4) tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = BB'(32'hD000_0000 + i);
      #1;
      vectors++;
      if (rd_valid_o !== 4'(1 << p[i]) ||
          rd_data_o !== BB'(32'hD000_0000 + i)) begin
        miscompares++;
        $display("FAIL rd_ret[%0d]: got %b/%h expected %b/%h",
                 i, rd_valid_o, rd_data_o, 4'(1 << p[i]),
                 BB'(32'hD000_0000 + i));
      end
      tick();
      mem_rvalid_i = 1'b0;
    end
    vectors++;
    if (rd_outst_o !== '0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_drain: got %0d/%b expected 0/0",
               rd_outst_o, err_o);
    end
  endtask

  task automatic test_outst_limit();
    int g [4];
    int h [4];
    g = '{1, 2, 3, 0};
    h = '{2, 3, 0, 1};
    rd_req_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (rd_gnt_o !== 4'(1 << g[i])) begin
        miscompares++;
        $display("FAIL lim_gnt[%0d]: got %b expected %b",
                 i, rd_gnt_o, 4'(1 << g[i]));
      end
      tick();
    end
    #1;
    vectors++;
    if (rd_gnt_o !== '0 || rd_outst_o !== CW'(4)) begin
      miscompares++;
      $display("FAIL lim_full: got %b/%0d expected 0000/4",
               rd_gnt_o, rd_outst_o);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = BB'(32'h5555_0001);
    #1;
    vectors++;
    if (rd_gnt_o !== '0 || rd_valid_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL lim_gate: got %b/%b expected 0000/0010",
               rd_gnt_o, rd_valid_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    vectors++;
    if (rd_outst_o !== CW'(3) || rd_gnt_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL lim_resume: got %0d/%b expected 3/0010",
               rd_outst_o, rd_gnt_o);
    end
    tick();
    rd_req_i = '0;
    vectors++;
    if (rd_outst_o !== CW'(4)) begin
      miscompares++;
      $display("FAIL lim_refill: got %0d expected 4", rd_outst_o);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1;
      #1;
      vectors++;
      if (rd_valid_o !== 4'(1 << h[i])) begin
        miscompares++;
        $display("FAIL lim_ret[%0d]: got %b expected %b",
                 i, rd_valid_o, 4'(1 << h[i]));
      end
      tick();
    end
    mem_rvalid_i = 1'b0;
    vectors++;
    if (rd_outst_o !== '0) begin
      miscompares++;
      $display("FAIL lim_drain: got %0d expected 0", rd_outst_o);
    end
  endtask

  task automatic test_err_reset();
    mem_rvalid_i = 1'b1;
    #1;
    vectors++;
    if (rd_valid_o !== '0) begin
      miscompares++;
      $display("FAIL err_strobe: got %b expected 0000", rd_valid_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    repeat (3) tick();
    vectors++;
    if (err_o !== 1'b1 || rd_outst_o !== '0) begin
      miscompares++;
      $display("FAIL err_sticky: got %b/%0d expected 1/0",
               err_o, rd_outst_o);
    end
    rd_req_i = 4'b1100;
    tick();
    tick();
    rd_req_i = '0;
    vectors++;
    if (rd_outst_o !== CW'(2)) begin
      miscompares++;
      $display("FAIL err_outst2: got %0d expected 2", rd_outst_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_outst_o !== '0 || err_o !== 1'b0 || mem_re_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: got %0d/%b/%b expected 0/0/0",
               rd_outst_o, err_o, mem_re_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    vectors++;
    if (rd_valid_o !== '0) begin
      miscompares++;
      $display("FAIL stale_strobe: got %b expected 0000", rd_valid_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_err: got %b expected 1", err_o);
    end
    do_reset();
  endtask

  task automatic test_lock();
    int e [4];
`ifdef ARB_LOCK_EN
    e = '{1, 1, 1, 1};
`else
    e = '{1, 2, 0, 1};
`endif
    wr_req_i = 4'b0001;
    tick();
    wr_req_i  = 4'b0111;
    wr_lock_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (wr_gnt_o !== 4'(1 << e[i])) begin
        miscompares++;
        $display("FAIL lock_gnt[%0d]: got %b expected %b",
                 i, wr_gnt_o, 4'(1 << e[i]));
      end
      tick();
    end
    wr_req_i  = 4'b0101;
    wr_lock_i = '0;
    #1;
    vectors++;
    if (wr_gnt_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL lock_release: got %b expected 0100", wr_gnt_o);
    end
    tick();
    wr_req_i = '0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      wr_addr_i[k*AW +: AW] = AW'(256 + k);
      rd_addr_i[k*AW +: AW] = AW'(512 + k);
      wr_data_i[k*BB +: BB] = BB'(32'hA000_0000 + k);
    end
    test_reset();
    test_rr_all();
    test_work_conserving();
    test_read_order();
    test_outst_limit();
    test_err_reset();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
